// File: rtl/scan_decoder_pkg.sv
// Shared FSM state encodings and mode constants for the scan decoder slice.
// Latency: none (declarations only).
// Backpressure: not applicable.
package scan_decoder_pkg;

    // FSM state encodings
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    // Values of the mode input
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_prescaler.sv
// Prescaler for scan mode: counts up to div_tc and emits an advance pulse.
// Latency: adv is combinational from the current count; the count updates on the next edge.
// Backpressure: none; clr overrides run, and with neither asserted the count is held.
module scan_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             run,
    input  logic [DIV_W-1:0] div_tc,
    output logic             adv
);

    localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

    logic [DIV_W-1:0] count;

    // Greater-or-equal compare means a div_tc lowered below the count wraps
    // on the next edge rather than running all the way round the counter.
    assign adv = run && (count >= div_tc);

    // Count register: clear has priority, otherwise count while running, else hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (run) begin
            count <= adv ? '0 : (count + CNT_ONE);
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered 1-of-2^SEL_W decoder with DIRECT and prescaled SCAN modes; SCAN_BLANK_EN adds a blank cycle after each scan advance.
// Latency: 1 cycle from sampled inputs to d_out / sel_idx / tick.
// Backpressure: none; en=0 parks outputs inactive and freezes index and prescaler.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int DIV_W      = 16,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      d_in,
    input  logic [DIV_W-1:0]      div_tc,
    output logic [(1<<SEL_W)-1:0] d_out,
    output logic [SEL_W-1:0]      sel_idx,
    output logic                  tick
);

    localparam int               N       = 1 << SEL_W;
    localparam logic [N-1:0]     D_IDLE  = ACTIVE_LOW ? {N{1'b1}} : {N{1'b0}};
    localparam logic [SEL_W-1:0] SEL_ONE = SEL_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic             pre_clr;
    logic             pre_run;
    logic             pre_adv;
    logic [SEL_W-1:0] sel_d;
    logic             tick_d;
    logic [N-1:0]     onehot;
    logic [N-1:0]     d_out_d;

    // Prescaler clears while in (or leaving) DIRECT; it only counts across
    // SCAN->SCAN edges so a resume from IDLE keeps the frozen count intact.
    assign pre_clr = (state_d == ST_DIRECT) ||
                     ((state_q == ST_DIRECT) && (state_d == ST_SCAN));
    assign pre_run = (state_q == ST_SCAN) && (state_d == ST_SCAN);

    scan_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (pre_clr),
        .run    (pre_run),
        .div_tc (div_tc),
        .adv    (pre_adv)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: en has priority over mode from every state
    always_comb begin
        state_d = ST_IDLE;
        if (en) begin
            state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
        end
    end

    // Next output values, decoded from the state being entered
    always_comb begin
        sel_d   = sel_idx;
        tick_d  = 1'b0;
        onehot  = '0;
        d_out_d = D_IDLE;
        case (state_d)
            ST_DIRECT: sel_d = d_in;
            ST_SCAN: begin
                if (pre_adv) begin
                    sel_d  = sel_idx + SEL_ONE;
                    tick_d = 1'b1;
                end
            end
            default: sel_d = sel_idx;
        endcase
        onehot[sel_d] = 1'b1;
        if (state_d != ST_IDLE) begin
            d_out_d = ACTIVE_LOW ? ~onehot : onehot;
        end
`ifdef SCAN_BLANK_EN
        // Anti-ghosting: hold every line inactive for the cycle after an advance
        if (pre_adv) begin
            d_out_d = D_IDLE;
        end
`endif
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_idx <= '0;
            tick    <= 1'b0;
            d_out   <= D_IDLE;
        end else begin
            sel_idx <= sel_d;
            tick    <= tick_d;
            d_out   <= d_out_d;
        end
    end

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: default build (SEL_W=2, active-low) plus a SEL_W=1 active-high copy.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        mode;
    logic [1:0]  d_in;
    logic [15:0] div_tc;
    logic [3:0]  d_out;
    logic [1:0]  sel_idx;
    logic        tick;
    logic [1:0]  d_out1;
    logic        sel1;
    logic        tick1;

    int vectors     = 0;
    int miscompares = 0;

    scan_decoder #(.SEL_W(2), .DIV_W(16), .ACTIVE_LOW(1'b1)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .d_in    (d_in),
        .div_tc  (div_tc),
        .d_out   (d_out),
        .sel_idx (sel_idx),
        .tick    (tick)
    );

    scan_decoder #(.SEL_W(1), .DIV_W(16), .ACTIVE_LOW(1'b0)) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .d_in    (d_in[0]),
        .div_tc  (div_tc),
        .d_out   (d_out1),
        .sel_idx (sel1),
        .tick    (tick1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected active-low 4-line pattern for index s in SCAN; adv marks an advance edge
    function automatic logic [3:0] exp_scan4(input int s, input bit adv);
        logic [3:0] one;
        one = 4'b0001;
`ifdef SCAN_BLANK_EN
        if (adv) return 4'b1111;
`endif
        return ~(one << s);
    endfunction

    // Expected active-high 2-line pattern for index s in SCAN
    function automatic logic [1:0] exp_scan2(input int s, input bit adv);
        logic [1:0] one;
        one = 2'b01;
`ifdef SCAN_BLANK_EN
        if (adv) return 2'b00;
`endif
        return one << s;
    endfunction

    logic [3:0] dir_exp [4];

    initial begin
        int s;
        bit a;
        dir_exp[0] = 4'b1110;
        dir_exp[1] = 4'b1101;
        dir_exp[2] = 4'b1011;
        dir_exp[3] = 4'b0111;

        rst_n  = 1'b1;
        en     = 1'b0;
        mode   = 1'b0;
        d_in   = 2'd0;
        div_tc = 16'd3;

        // Reset asserted mid-cycle takes effect immediately
        #2 rst_n = 1'b0;
        #1;
        chk("rst_dout", 32'(d_out), 32'hF);
        chk("rst_sel", 32'(sel_idx), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_dout1", 32'(d_out1), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("idle_dout", 32'(d_out), 32'hF);
        step();
        chk("idle_dout2", 32'(d_out), 32'hF);

        // DIRECT decode of 0..3, one cycle latency
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d_in = 2'(i);
            step();
            chk("dir_dout", 32'(d_out), 32'(dir_exp[i]));
            chk("dir_sel", 32'(sel_idx), 32'(i));
            chk("dir_tick", 32'(tick), 32'h0);
        end
        en = 1'b0;
        step();
        chk("dir_off_dout", 32'(d_out), 32'hF);
        chk("dir_off_sel", 32'(sel_idx), 32'h3);

        // Enter SCAN from DIRECT index 0, div_tc=3
        en   = 1'b1;
        d_in = 2'd0;
        step();
        chk("pre_scan_dout", 32'(d_out), 32'hE);
        mode = 1'b1;
        step();
        chk("scan_entry_dout", 32'(d_out), 32'hE);
        chk("scan_entry_tick", 32'(tick), 32'h0);
        for (int k = 1; k <= 16; k++) begin
            step();
            s = (k / 4) % 4;
            a = (k % 4) == 0;
            chk("scan3_tick", 32'(tick), 32'(a));
            chk("scan3_sel", 32'(sel_idx), 32'(s));
            chk("scan3_dout", 32'(d_out), 32'(exp_scan4(s, a)));
        end

        // div_tc=0: advance every cycle, tick held high; SEL_W=1 copy toggles
        div_tc = 16'd0;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("tc0_tick", 32'(tick), 32'h1);
            chk("tc0_sel", 32'(sel_idx), 32'(k % 4));
            chk("tc0_dout", 32'(d_out), 32'(exp_scan4(k % 4, 1'b1)));
            chk("tc0_sel1", 32'(sel1), 32'(k % 2));
            chk("tc0_tick1", 32'(tick1), 32'h1);
            chk("tc0_dout1", 32'(d_out1), 32'(exp_scan2(k % 2, 1'b1)));
        end

        // div_tc=9 for 6 edges (count reaches 6), then drop to 2
        div_tc = 16'd9;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("tc9_tick", 32'(tick), 32'h0);
            chk("tc9_sel", 32'(sel_idx), 32'h2);
        end
        div_tc = 16'd2;
        for (int k = 1; k <= 7; k++) begin
            step();
            a = (k == 1) || (k == 4) || (k == 7);
            s = (k < 4) ? 3 : ((k < 7) ? 0 : 1);
            chk("tc2_tick", 32'(tick), 32'(a));
            chk("tc2_sel", 32'(sel_idx), 32'(s));
        end

        // Reach sel_idx=2 with count 1
        for (int k = 1; k <= 4; k++) step();
        chk("frz_pre_sel", 32'(sel_idx), 32'h2);
        chk("frz_pre_dout", 32'(d_out), 32'hB);

        // Freeze for 5 cycles
        en = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("frz_dout", 32'(d_out), 32'hF);
            chk("frz_sel", 32'(sel_idx), 32'h2);
            chk("frz_tick", 32'(tick), 32'h0);
        end

        // Resume: two more cycles at index 2, then advance
        en = 1'b1;
        step();
        chk("res1_dout", 32'(d_out), 32'hB);
        chk("res1_tick", 32'(tick), 32'h0);
        step();
        chk("res2_sel", 32'(sel_idx), 32'h2);
        chk("res2_tick", 32'(tick), 32'h0);
        step();
        chk("res3_sel", 32'(sel_idx), 32'h3);
        chk("res3_tick", 32'(tick), 32'h1);
        chk("res3_dout", 32'(d_out), 32'(exp_scan4(3, 1'b1)));

        // en and mode drop together: en wins, outputs go inactive
        en   = 1'b0;
        mode = 1'b0;
        step();
        chk("prio_dout", 32'(d_out), 32'hF);
        chk("prio_tick", 32'(tick), 32'h0);
        en   = 1'b1;
        d_in = 2'd1;
        step();
        chk("prio_dir_dout", 32'(d_out), 32'hD);

        // Reset in the middle of a fast scan
        mode   = 1'b1;
        div_tc = 16'd0;
        step();
        chk("mid_entry_sel", 32'(sel_idx), 32'h1);
        step();
        chk("mid_adv_tick", 32'(tick), 32'h1);
        chk("mid_adv_sel", 32'(sel_idx), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_dout", 32'(d_out), 32'hF);
        chk("mid_rst_sel", 32'(sel_idx), 32'h0);
        chk("mid_rst_tick", 32'(tick), 32'h0);
        step();
        chk("mid_rst_hold", 32'(d_out), 32'hF);
        rst_n = 1'b1;
        en    = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
